// File: rtl/tt_pin_pkg.sv
// Shared types and pin/frame bit positions for the Tiny Tapeout pin-bus host.
package tt_pin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int REQ_BIT  = 0;
    localparam int ACK_BIT  = 0;
    localparam int WR_BIT   = 7;
    localparam int ADDR_MSB = 6;

    function automatic logic [7:0] make_byte0(input logic wr, input logic [ADDR_MSB:0] addr);
        logic [7:0] b;
        b = 8'd0;
        b[WR_BIT] = wr;
        b[ADDR_MSB:0] = addr;
        return b;
    endfunction

endpackage

// File: rtl/tt_pin_host_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module tt_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // shift the raw input one stage further each cycle
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{1'b0}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/tt_pin_host.sv
// Host-side initiator for the Tiny Tapeout pin bus: frames commands into req/ack
// toggle transfers on ui_in/uio_in and returns read data or an error.
module tt_pin_host
    import tt_pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] pin_ui_in,
    output logic [7:0] pin_uio_in,
    input  logic [7:0] pin_uo_out,
    input  logic [7:0] pin_uio_out,
    input  logic [7:0] pin_uio_oe
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_q, wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              idx_q, idx_d;
    logic              req_q, req_d;
    logic              ack_prev_q, ack_prev_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]        ui_q, ui_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              ack_s;
    logic              ack_edge_s;
    logic              accept_s;
    logic              oe_lost_s;
    logic              timeout_s;
    logic [TCNT_W-1:0] tcnt_inc_s;
    logic [7:0]        uio_in_s;
    logic              unused_s;

    tt_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_uio_out[ACK_BIT]),
        .q     (ack_s)
    );

    // handshake, edge and timeout qualifiers
    always_comb begin
        accept_s   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
        ack_edge_s = (ack_s != ack_prev_q);
        oe_lost_s  = !pin_uio_oe[ACK_BIT];
        tcnt_inc_s = (tcnt_q == TCNT_LIMIT) ? tcnt_q : (tcnt_q + TCNT_W'(1));
        timeout_s  = (tcnt_inc_s == TCNT_LIMIT);
    end

    // next-state logic; a lost ack driver outranks the ack edge, which outranks timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = SETUP;
                else          state_d = IDLE;
            end
            SETUP: state_d = WAIT;
            WAIT: begin
                if (oe_lost_s)                   state_d = RESP;
                else if (ack_edge_s && wr_q && !idx_q) state_d = SETUP;
                else if (ack_edge_s || timeout_s) state_d = RESP;
                else                             state_d = WAIT;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
                else           state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath and response next values
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        req_d       = req_q;
        ack_prev_d  = ack_prev_q;
        tcnt_d      = tcnt_q;
        ui_d        = ui_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                ack_prev_d = ack_s;
                if (accept_s) begin
                    wr_d    = cmd_write;
                    wdata_d = cmd_wdata;
                    ui_d    = make_byte0(cmd_write, cmd_addr);
                    idx_d   = 1'b0;
                end else begin
                    ui_d = ui_q;
                end
            end
            SETUP: begin
                req_d  = ~req_q;
                tcnt_d = {TCNT_W{1'b0}};
            end
            WAIT: begin
                tcnt_d = tcnt_inc_s;
                if (oe_lost_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'd0;
                end else if (ack_edge_s) begin
                    ack_prev_d = ack_s;
                    if (wr_q && !idx_q) begin
                        ui_d  = wdata_q;
                        idx_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = wr_q ? 8'd0 : pin_uo_out;
                    end
                end else if (timeout_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'd0;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 8'd0;
                    rsp_err_d   = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'd0;
            idx_q       <= 1'b0;
            req_q       <= 1'b0;
            ack_prev_q  <= 1'b0;
            tcnt_q      <= {TCNT_W{1'b0}};
            ui_q        <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            ack_prev_q  <= ack_prev_d;
            tcnt_q      <= tcnt_d;
            ui_q        <= ui_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // uio_in carries only the req toggle
    always_comb begin
        uio_in_s          = 8'd0;
        uio_in_s[REQ_BIT] = req_q;
    end

    assign unused_s   = ^{pin_uio_out[7:1], pin_uio_oe[7:1]};
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign pin_ui_in  = ui_q;
    assign pin_uio_in = uio_in_s;

endmodule

// File: tb/tb_tt_pin_host.sv
// Bench for tt_pin_host: behavioural tile model, response scoreboard, vector table.
module tb_tt_pin_host;

    localparam int TIMEOUT = 16;
    localparam int SYNC    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_ready = 1'b1;
    logic       cmd_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata, pin_ui_in, pin_uio_in;
    logic [7:0] pin_uo_out, pin_uio_out, pin_uio_oe;

    logic       tile_ack = 1'b0;
    logic       tile_oe = 1'b1;
    logic [7:0] tile_uo = 8'd0;
    logic       tile_en = 1'b1;
    int         tile_delay = 0;
    logic       tile_last_req = 1'b0;
    logic       tile_pending = 1'b0;
    int         tile_cnt = 0;
    logic       tile_expect_data = 1'b0;
    logic [6:0] tile_waddr = 7'd0;
    logic [7:0] tile_rd = 8'd0;
    logic [7:0] tile_mem [128];
    logic [7:0] byte_log [$];
    int         toggles = 0;
    int         toggle_cyc = 0;
    int         cyc = 0;

    typedef struct { logic [7:0] rdata; logic err; } exp_t;
    exp_t sb_q [$];
    int   valid_cyc = 0;
    logic valid_prev = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;

    assign pin_uo_out  = tile_uo;
    assign pin_uio_out = {7'd0, tile_ack};
    assign pin_uio_oe  = {7'd0, tile_oe};

    tt_pin_host #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .pin_ui_in   (pin_ui_in),
        .pin_uio_in  (pin_uio_in),
        .pin_uo_out  (pin_uo_out),
        .pin_uio_out (pin_uio_out),
        .pin_uio_oe  (pin_uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Tile model: reacts to req toggles, decodes frames, acks after tile_delay cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            tile_last_req    = 1'b0;
            tile_pending     = 1'b0;
            tile_expect_data = 1'b0;
        end else begin
            if (pin_uio_in[0] != tile_last_req) begin
                tile_last_req = pin_uio_in[0];
                byte_log.push_back(pin_ui_in);
                toggles++;
                toggle_cyc = cyc;
                if (tile_expect_data) begin
                    tile_mem[tile_waddr] = pin_ui_in;
                    tile_expect_data = 1'b0;
                    tile_rd = 8'd0;
                end else if (pin_ui_in[7]) begin
                    tile_expect_data = 1'b1;
                    tile_waddr = pin_ui_in[6:0];
                    tile_rd = 8'd0;
                end else begin
                    tile_rd = tile_mem[pin_ui_in[6:0]];
                end
                tile_pending = 1'b1;
                tile_cnt = 0;
            end
            if (tile_pending) begin
                if (tile_cnt >= tile_delay) begin
                    tile_pending = 1'b0;
                    if (tile_en) begin
                        tile_ack = ~tile_ack;
                        tile_uo  = tile_rd;
                    end
                end else begin
                    tile_cnt++;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && !valid_prev) valid_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=0x%0h expected=none", rsp_rdata);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                    check("rsp_err", int'(rsp_err), int'(e.err));
                end
            end
            valid_prev = rsp_valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee);
        int   n;
        exp_t e;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        e.rdata = er;
        e.err   = ee;
        sb_q.push_back(e);
        exp_total += (w ? 2 : 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] b0;
        logic [7:0] rdata;
    } vec_t;

    vec_t vec [6];

    initial begin
        int   n;
        int   tog0;
        logic stable;

        for (int i = 0; i < 128; i++) tile_mem[i] = 8'h00;
        tile_mem[7'h11] = 8'hC3;
        tile_mem[7'h00] = 8'h3C;

        vec[0] = '{1'b1, 7'h05, 8'h2A, 3, 8'h85, 8'h00};
        vec[1] = '{1'b0, 7'h11, 8'h00, 0, 8'h11, 8'hC3};
        vec[2] = '{1'b0, 7'h05, 8'h00, 1, 8'h05, 8'h2A};
        vec[3] = '{1'b1, 7'h7F, 8'hFF, 2, 8'hFF, 8'h00};
        vec[4] = '{1'b0, 7'h7F, 8'h00, 0, 8'h7F, 8'hFF};
        vec[5] = '{1'b0, 7'h00, 8'h00, 4, 8'h00, 8'h3C};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_rdata", int'(rsp_rdata), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_pin_ui_in", int'(pin_ui_in), 0);
        check("rst_pin_uio_in", int'(pin_uio_in), 0);
        rst_n = 1'b1;
        n = 0;
        while (!cmd_ready && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_after_reset", int'(cmd_ready), 1);

        // table-driven single transfers
        for (int i = 0; i < 6; i++) begin
            tile_delay = vec[i].delay;
            byte_log.delete();
            tog0 = toggles;
            send(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].rdata, 1'b0);
            wait_idle("vec_done");
            check("vec_toggles", toggles - tog0, vec[i].wr ? 2 : 1);
            check("vec_bytes", byte_log.size(), vec[i].wr ? 2 : 1);
            if (byte_log.size() > 0) check("vec_byte0", int'(byte_log[0]), int'(vec[i].b0));
            if (vec[i].wr && byte_log.size() > 1) check("vec_byte1", int'(byte_log[1]), int'(vec[i].wdata));
            if (!vec[i].wr) check("read_latency", valid_cyc - toggle_cyc, SYNC + 1 + vec[i].delay);
            check("vec_req_level", int'(pin_uio_in[0]), exp_total % 2);
        end

        // tile never acks: timeout
        tile_en = 1'b0;
        send(1'b0, 7'h22, 8'h00, 8'h00, 1'b1);
        wait_idle("timeout_done");
        check("timeout_latency", valid_cyc - toggle_cyc, TIMEOUT);
        check("timeout_req_level", int'(pin_uio_in[0]), exp_total % 2);
        tile_en = 1'b1;

        // response back-pressure; a command offered meanwhile is ignored
        rsp_ready = 1'b0;
        tile_delay = 0;
        send(1'b0, 7'h11, 8'h00, 8'hC3, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_valid_seen", int'(rsp_valid), 1);
        tog0 = toggles;
        stable = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 7'h33;
        cmd_wdata = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata != 8'hC3 || rsp_err || cmd_ready) stable = 1'b0;
        end
        check("hold_stable", int'(stable), 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("hold_release");
        repeat (5) @(posedge clk);
        #1;
        check("hold_no_new_req", toggles - tog0, 0);
        check("hold_ready_back", int'(cmd_ready), 1);

        // reset in the middle of a write's WAIT
        tile_delay = 50;
        send(1'b1, 7'h40, 8'h55, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", int'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, pin_ui_in, pin_uio_in}), 0);
        sb_q.delete();
        exp_total = 0;
        tile_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tile_delay = 0;
        send(1'b0, 7'h11, 8'h00, 8'hC3, 1'b0);
        wait_idle("midrst_read");
        check("midrst_req_level", int'(pin_uio_in[0]), 1);

        // tile stops driving ack during WAIT
        tile_delay = 30;
        send(1'b0, 7'h05, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        tile_oe = 1'b0;
        @(posedge clk); #1;
        check("oe_err", int'(rsp_err), 1);
        check("oe_valid", int'(rsp_valid), 1);
        tile_oe = 1'b1;
        wait_idle("oe_done");
        repeat (40) @(posedge clk);
        #1;

        // back-to-back alternating write/read
        tog0 = toggles;
        for (int k = 0; k < 8; k++) begin
            tile_delay = k % 3;
            if (k % 2 == 0) send(1'b1, 7'(96 + k), 8'(160 + k), 8'h00, 1'b0);
            else            send(1'b0, 7'(96 + k - 1), 8'h00, 8'(160 + k - 1), 1'b0);
        end
        wait_idle("b2b_done");
        check("b2b_toggles", toggles - tog0, 12);
        check("b2b_req_level", int'(pin_uio_in[0]), exp_total % 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
